// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage constants, FSM state type and buffer entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: imem req/gnt/rvalid bus plus redirect and decode valid/stall handshake of the fetch stage
interface fetch_if;
  import riscv_pkg::*;
  logic imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic imem_gnt_i;
  logic imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic stall_i;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] pc_o;
  logic instr_valid_o;
  modport master (
    output imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
    input imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );
  modport slave (
    input imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of {pc, instr} entries with push/pop/flush and head/count outputs
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fetch_entry_t           i_data,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_count;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else begin
      r_wr <= r_wr + AW'(i_push);
      r_rd <= r_rd + AW'(i_pop);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  always_ff @(posedge i_clk)
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  assign o_head = r_mem[r_rd];
  assign o_count = r_count;
  assign o_empty = r_count == '0;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches words over req/gnt/rvalid and feeds them to decode through a small buffer
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_1000,
  parameter int BUF_DEPTH = 2
) (
  input logic clk_i,
  input logic rsn_i,
  fetch_if.master bus
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  fetch_state_t r_state, w_state_nx;
  logic [XLEN-1:0] r_pc, r_req_pc, w_pc_nx, w_redir_pc;
  logic [CW-1:0] w_count, w_count_nx;
  logic w_empty, w_push, w_pop, w_flush, w_room, w_gnt;
  fetch_entry_t w_head, w_entry;
  assign w_flush = bus.redirect_i;
  assign w_redir_pc = bus.redirect_pc_i & ~XLEN'(3);
  assign w_gnt = r_state == REQ && bus.imem_gnt_i;
  assign w_pop = !w_empty && !bus.stall_i;
  assign w_push = r_state == WAIT && bus.imem_rvalid_i && !w_flush;
  assign w_entry = {r_req_pc, bus.imem_rdata_i};
  assign w_count_nx = w_flush ? '0 : w_count + CW'(w_push) - CW'(w_pop);
  assign w_room = w_count_nx < CW'(BUF_DEPTH);
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx = w_flush ? w_redir_pc : w_gnt ? r_pc + XLEN'(4) : r_pc;
    case (r_state)
      IDLE:    w_state_nx = w_room ? REQ : IDLE;
      REQ:     w_state_nx = bus.imem_gnt_i ? (w_flush ? FLUSH : WAIT) : REQ;
      WAIT:    w_state_nx = bus.imem_rvalid_i ? (w_room ? REQ : IDLE) : (w_flush ? FLUSH : WAIT);
      FLUSH:   w_state_nx = bus.imem_rvalid_i ? (w_room ? REQ : IDLE) : FLUSH;
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rsn_i)
    if (rsn_i) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      r_req_pc <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pc <= w_pc_nx;
      if (w_gnt) r_req_pc <= r_pc;
    end
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .i_clk(clk_i),
    .i_rst(rsn_i),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_flush(w_flush),
    .i_data(w_entry),
    .o_head(w_head),
    .o_count(w_count),
    .o_empty(w_empty)
  );
  assign bus.imem_req_o = r_state == REQ;
  assign bus.imem_addr_o = r_pc;
  assign bus.instr_valid_o = !w_empty;
  assign bus.instr_o = w_empty ? NOP_INSTR : w_head.instr;
  assign bus.pc_o = w_empty ? '0 : w_head.pc;
endmodule
